// File: rtl/seq_divider_16.sv
// Sequential restoring divider: one quotient bit per clock, start/done handshake.
// Divide-by-zero short-circuits straight to DONE with all-ones quotient.
module seq_divider_16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] q, r, d;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_nx, r_nx;
  logic             last;

  // r stays below 2**(WIDTH-1) before each shift, so {r, q msb} equals the
  // zero-extended shifted remainder and the subtract needs no extra guard bit.
  always_comb begin
    trial = {r, q[WIDTH-1]} - {1'b0, d};
    q_nx  = {q[WIDTH-2:0], ~trial[WIDTH]};
    r_nx  = trial[WIDTH] ? {r[WIDTH-2:0], q[WIDTH-1]} : trial[WIDTH-1:0];
    last  = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    state_nxt = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE: begin
        if (Start) state_nxt = (Divisor == '0) ? DONE : RUN;
      end
      RUN: begin
        Busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      q         <= '0;
      r         <= '0;
      d         <= '0;
      cnt       <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            if (Divisor == '0) begin
              Quotient  <= '1;
              Remainder <= Dividend;
              DivByZero <= 1'b1;
            end else begin
              q   <= Dividend;
              d   <= Divisor;
              r   <= '0;
              cnt <= '0;
            end
          end
        end
        RUN: begin
          q   <= q_nx;
          r   <= r_nx;
          cnt <= cnt + 1'b1;
          if (last) begin
            Quotient  <= q_nx;
            Remainder <= r_nx;
            DivByZero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_16.sv
// Bench for seq_divider_16: vector table, hand-written corner sequences and a
// random sweep, all checked through a queue of expected completions.
module tb_seq_divider_16;

  localparam int unsigned W = 16;

  logic         Clk = 1'b0;
  logic         Reset, Start;
  logic [W-1:0] Dividend, Divisor;
  logic [W-1:0] Quotient, Remainder;
  logic         DivByZero, Busy, Done;

  seq_divider_16 #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .Dividend(Dividend), .Divisor(Divisor),
    .Quotient(Quotient), .Remainder(Remainder),
    .DivByZero(DivByZero), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  int unsigned cyc = 0;
  always @(posedge Clk) cyc++;

  typedef struct {
    logic [W-1:0] q, r;
    logic         dbz;
    int unsigned  done_cyc;
    int unsigned  busy;
  } exp_t;

  typedef struct {
    logic [W-1:0] a, b, q, r;
    logic         dbz;
  } vec_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected completion for a Start sampled at edge 'acc'.
  task automatic push_exp(input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edbz, input int unsigned acc);
    exp_t e;
    e.q = eq; e.r = er; e.dbz = edbz;
    e.busy     = edbz ? 0 : W;
    e.done_cyc = edbz ? acc : acc + W;
    sb.push_back(e);
  endtask

  logic        prev_done = 1'b0;
  int unsigned busy_cnt = 0;
  int unsigned done_seen = 0;

  always @(negedge Clk) begin
    exp_t e;
    if (Reset) begin
      prev_done = 1'b0;
      busy_cnt  = 0;
    end else begin
      if (prev_done) check("done_width", Done, 0);
      if (Busy) busy_cnt++;
      if (Done) begin
        done_seen++;
        check("busy_with_done", Busy, 0);
        if (sb.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          check("quotient", Quotient, e.q);
          check("remainder", Remainder, e.r);
          check("divbyzero", DivByZero, e.dbz);
          check("latency", cyc, e.done_cyc);
          check("busy_cycles", busy_cnt, e.busy);
        end
        busy_cnt = 0;
      end
      prev_done = Done;
    end
  end

  task automatic wait_done(output int unsigned at);
    int unsigned i;
    at = 0;
    for (i = 0; i < 40; i++) begin
      if (Done) break;
      @(negedge Clk);
    end
    if (Done) at = cyc;
    else check("done_timeout", 0, 1);
  endtask

  // Called just after a negedge with the DUT idle at the next edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
    int unsigned at;
    Dividend = a; Divisor = b; Start = 1'b1;
    push_exp(eq, er, edbz, cyc + 1);
    @(negedge Clk);
    Start = 1'b0;
    Dividend = W'($urandom); Divisor = W'($urandom);
    wait_done(at);
    @(negedge Clk);
  endtask

  vec_t vt[10];

  initial begin
    int unsigned d1, d2, seen;
    logic [W-1:0] a, b;

    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int unsigned d1, d2, seen;
    logic [W-1:0] a, b;

    vt[0] = '{a:16'd100,   b:16'd7,      q:16'd14,     r:16'd2,    dbz:1'b0};
    vt[1] = '{a:16'hFFFF,  b:16'd1,      q:16'hFFFF,   r:16'd0,    dbz:1'b0};
    vt[2] = '{a:16'd5,     b:16'd9,      q:16'd0,      r:16'd5,    dbz:1'b0};
    vt[3] = '{a:16'hFFFF,  b:16'hFFFF,   q:16'd1,      r:16'd0,    dbz:1'b0};
    vt[4] = '{a:16'd1234,  b:16'd0,      q:16'hFFFF,   r:16'd1234, dbz:1'b1};
    vt[5] = '{a:16'd1000,  b:16'd3,      q:16'd333,    r:16'd1,    dbz:1'b0};
    vt[6] = '{a:16'd0,     b:16'd5,      q:16'd0,      r:16'd0,    dbz:1'b0};
    vt[7] = '{a:16'h8000,  b:16'd2,      q:16'h4000,   r:16'd0,    dbz:1'b0};
    vt[8] = '{a:16'd7,     b:16'd0,      q:16'hFFFF,   r:16'd7,    dbz:1'b1};
    vt[9] = '{a:16'hABCD,  b:16'h0100,   q:16'h00AB,   r:16'h00CD, dbz:1'b0};

    Reset = 1'b1; Start = 1'b0; Dividend = '0; Divisor = '0;
    repeat (3) @(negedge Clk);
    check("rst_quotient", Quotient, 0);
    check("rst_remainder", Remainder, 0);
    check("rst_divbyzero", DivByZero, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    Reset = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < 10; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].dbz);
      @(negedge Clk);
      check("hold_quotient", Quotient, vt[i].q);
      check("hold_remainder", Remainder, vt[i].r);
      check("hold_divbyzero", DivByZero, vt[i].dbz);
    end

    // Start held high, operands swapped mid-run: second op begins only from IDLE.
    Dividend = 16'd50000; Divisor = 16'd123; Start = 1'b1;
    push_exp(16'd406, 16'd62, 1'b0, cyc + 1);
    repeat (3) @(negedge Clk);
    Dividend = 16'd999; Divisor = 16'd10;
    wait_done(d1);
    @(negedge Clk);
    push_exp(16'd99, 16'd9, 1'b0, cyc + 1);
    @(negedge Clk);
    Start = 1'b0;
    wait_done(d2);
    check("done_interval", d2 - d1, W + 2);
    @(negedge Clk);

    // Reset in the eighth RUN cycle aborts with no completion.
    Dividend = 16'd1000; Divisor = 16'd3; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (7) @(negedge Clk);
    Reset = 1'b1;
    sb.delete();
    @(negedge Clk);
    check("abort_quotient", Quotient, 0);
    check("abort_remainder", Remainder, 0);
    check("abort_divbyzero", DivByZero, 0);
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    Reset = 1'b0;
    seen = done_seen;
    repeat (20) @(negedge Clk);
    check("no_done_after_abort", done_seen - seen, 0);
    run_op(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom_range(0, 65535));
      b = (i % 2 == 0) ? W'($urandom_range(1, 65535)) : W'($urandom_range(1, 255));
      run_op(a, b, a / b, a % b, 1'b0);
      check("identity", 64'(Quotient) * 64'(b) + 64'(Remainder), 64'(a));
      check("rem_lt_div", Remainder < b, 1);
    end

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider_16.md
# seq_divider_16

Sequential restoring divider: the subtract-and-shift counterpart to the team's adder blocks, which are add-only and combinational. It accepts an unsigned dividend and divisor on a start pulse and iterates one quotient bit per clock. It presents the quotient, remainder and a divide-by-zero flag with a one-cycle done pulse. It sits beside the adder blocks as the datapath's division unit, driven by a simple start/done handshake from the control FSM.

## Interface
- WIDTH, 16, operand/result width in bits (≥2)
- Clk  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high; clears all state and outputs on next rising edge
- Start  in  1  request; sampled only in IDLE
- Dividend  in  WIDTH  unsigned dividend, sampled with Start
- Divisor  in  WIDTH  unsigned divisor, sampled with Start
- Quotient  out  WIDTH  registered result, valid from Done, held until next accepted Start completes
- Remainder  out  WIDTH  registered result, same validity as Quotient
- DivByZero  out  1  registered flag, set with Done when Divisor was 0
- Busy  out  1  high while in RUN
- Done  out  1  single-cycle completion pulse

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE, Start=1, Divisor≠0:
  - Latch Dividend into working Q and Divisor into D.
  - Clear working R (WIDTH bits) and iteration counter.
  - Go to RUN.
- IDLE, Start=1, Divisor=0:
  - Load Quotient = all ones, Remainder = Dividend, DivByZero = 1.
  - Go to DONE. No iterations.
- RUN, per cycle:
  - Shift {R,Q} left one bit.
  - Form trial = {1'b0,R_shifted} − {1'b0,D} in WIDTH+1 bits.
  - If the trial MSB is 0: R ← trial[WIDTH-1:0] and Q[0] ← 1. Otherwise R keeps the shifted value and Q[0] ← 0.
  - Counter increments.
  - After the WIDTH-th iteration, load Quotient ← Q, Remainder ← R, DivByZero ← 0, then go to DONE.
- DONE: Done=1 for exactly this cycle, then go to IDLE unconditionally.
- Start is ignored in RUN and DONE. A Start in the DONE cycle is dropped. The requester must re-assert Start in IDLE.
- Output registers change only on entry to DONE or on Reset. Between operations they hold the last result.
- Dividend and Divisor may change freely after the Start cycle without affecting the operation.
- Unsigned only. Results satisfy Dividend = Quotient·Divisor + Remainder and Remainder < Divisor.

## Timing
- Reset values: Quotient=0, Remainder=0, DivByZero=0, Busy=0, Done=0, state IDLE.
- Reset takes priority over all other activity. Reset asserted mid-RUN aborts at the next edge, with no Done and outputs zeroed.
- Normal division, Start sampled at edge k:
  - Busy high after edges k .. k+WIDTH−1, i.e. WIDTH cycles.
  - Results loaded and Done high in the cycle after edge k+WIDTH.
  - Latency: WIDTH+1 cycles from Start to Done (17 for WIDTH=16).
- Divide by zero, Start sampled at edge k: Done high in the cycle after edge k (latency 1). Busy never asserts.
- Throughput: next Start is accepted in the IDLE cycle after DONE. Minimum issue interval is WIDTH+2 cycles for normal divisions and 2 cycles for divide-by-zero.
- Busy and Done are never high together.

## Test plan
- Reset, then Start with Dividend=100, Divisor=7 → Busy for 16 cycles; Done 17 cycles after Start with Quotient=14, Remainder=2, DivByZero=0.
- Dividend=0xFFFF, Divisor=1 → Quotient=0xFFFF, Remainder=0. Then Dividend=5, Divisor=9 → Quotient=0, Remainder=5. Then Dividend=0xFFFF, Divisor=0xFFFF → Quotient=1, Remainder=0.
- Dividend=1234, Divisor=0 → Done one cycle after Start; Quotient=0xFFFF, Remainder=1234, DivByZero=1, Busy never high. The next normal division clears DivByZero.
- Start=1 held continuously with operands changed mid-RUN → first result matches the originally latched operands. The next operation starts only from IDLE, and the interval between Done pulses is 18 cycles.
- Reset asserted at cycle 8 of RUN for 1000/3 → all outputs 0 the next cycle, no Done. A following 1000/3 returns Quotient=333, Remainder=1.
- Randomized sweep of 1000 operand pairs, Divisor≠0, against reference model → Quotient·Divisor+Remainder=Dividend and Remainder<Divisor every time; Done is exactly one cycle wide.
